rr_arbiter: RTL and testbench
=============================

// Module: rr_arbiter
// PURPOSE
//  Registered N-way arbiter, successor to the combinational fixed-priority arbiter.
//  Adds round-robin fairness, grant hold until the owner drops its request, and a one-cycle registered grant.
//  Sits in front of shared resources (bus, memory port, FIFO write side), one instance per resource.
//  Optional hold timeout preempts an owner that monopolises the resource.
// PARAMETERS
//  NumRequests  4  number of requesters, >=2
//  Mode         0  0 = round-robin; 1 = fixed priority, index 0 highest
//  MaxHold      8  ARB_TIMEOUT_EN only: max consecutive grant cycles before preemption, >=2
//  SelW         $clog2(NumRequests)  localparam, select width
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous active-low reset
//  request      in   NumRequests  request vector; a requester holds its bit high while it wants or owns the resource
//  grant        out  NumRequests  registered one-hot grant, or all-zero
//  grant_valid  out  1            high when any grant bit is set
//  select       out  SelW         index of the granted requester; 0 when grant_valid=0
//  preempt      out  1            one-cycle pulse on a timeout preemption; constant 0 without the macro
// BEHAVIOUR
//  Reset: async assert clears grant=0, grant_valid=0, select=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE.
//   Release is used synchronously; the first arbitration happens on the first edge after release.
//  States:
//   IDLE: no owner. At each edge, if request!=0, grant the winner and go to BUSY; else stay.
//   BUSY: owner k. At each edge, if request[k]=1, keep the grant.
//     If request[k]=0, arbitrate among the current requests. On a winner, grant it and stay BUSY (no bubble).
//     With no requests, clear the grant and go to IDLE.
//  Latency: request sampled at edge n; grant visible after edge n. Release is seen one edge after request[k] falls.
//  Winner:
//   Mode 0: first set bit scanning upward from ptr, wrapping N-1 -> 0.
//   Mode 1: lowest set index; ptr is unused.
//  Pointer: on every new grant to index w, ptr <= (w+1) mod N. It does not change while the grant is held.
//  Requests arriving while an owner holds the grant wait. Changes to non-owner bits never disturb the owner.
//  Simultaneous release of the owner and a new request: the new request is arbitrated in the same edge.
//  select and grant always agree; grant is never multi-hot.
//  Reset mid-grant clears everything at once. The ptr restart at 0 is intended.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   hold_cnt (width $clog2(MaxHold)+1) clears on each new grant and increments each BUSY cycle the owner is held.
//   When hold_cnt = MaxHold-1 and any other request bit is set, the edge re-arbitrates with the owner masked out.
//     The winner is granted, ptr is updated, and preempt pulses for one cycle.
//     The old owner may re-request; it competes normally.
//   With no other requester, the owner keeps the grant and hold_cnt saturates at MaxHold-1.
//   Applies in both Modes. In Mode 1, preemption picks the lowest other index.
//  ARB_TIMEOUT_EN undefined: no counter logic; preempt tied 0; the owner holds indefinitely.
// TESTING  (NumRequests=4, MaxHold=8 unless noted)
//  1 Reset: assert rst_n=0 mid-run -> grant=0000, grant_valid=0, select=0, preempt=0 immediately.
//    After release, request=1111 -> grant=0001.
//  2 Single request: request=0100 at edge n -> grant=0100, select=2 after edge n.
//    Drop at edge m -> grant=0000, grant_valid=0 after edge m+1.
//  3 Mode 0 fairness: all four requesting, each owner drops for 1 cycle after 2 cycles held.
//    -> grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycle between owners.
//  4 Mode 1: request=1010, owner 1 pulses low one cycle each time.
//    -> grant stays 0010 after every re-arbitration; 1000 is never granted while bit 1 competes.
//  5 Hold: owner 2 held, request bits 0,3 toggled every cycle.
//    -> grant stays 0100 and ptr unchanged (no macro).
//  6 ARB_TIMEOUT_EN: request0 held from cycle 0, request1 raised at cycle 2.
//    -> after 8 grant cycles grant=0010 with a one-cycle preempt.
//    Alone: 0001 held 20 cycles, no preempt.

Source files
------------

// File: rtl/rr_arbiter.sv
// Registered N-way arbiter: round-robin (Mode 0) or fixed priority (Mode 1), grant held until the owner drops its request.
// Latency: request sampled at edge n, grant/select visible after edge n; the owner's release re-arbitrates in that same edge.
// Backpressure: waiting requesters stay pending behind the owner; optional ARB_TIMEOUT_EN preempts an owner after MaxHold cycles.
module rr_arbiter #(
    parameter  int NumRequests = 4,
    parameter  int Mode        = 0,
    parameter  int MaxHold     = 8,
    localparam int SelW        = $clog2(NumRequests)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NumRequests-1:0] request,
    output logic [NumRequests-1:0] grant,
    output logic                   grant_valid,
    output logic [SelW-1:0]        select,
    output logic                   preempt
);

    localparam logic [0:0]    StIdle  = 1'b0;
    localparam logic [0:0]    StBusy  = 1'b1;
    localparam logic [SelW:0] NumReqW = (SelW+1)'(NumRequests);
    localparam logic [SelW-1:0] LastIdx = SelW'(NumRequests-1);

    if (NumRequests < 2) begin : g_chk_num_requests
        $error("rr_arbiter: NumRequests must be >= 2");
    end
    if (MaxHold < 2) begin : g_chk_max_hold
        $error("rr_arbiter: MaxHold must be >= 2");
    end

    logic [0:0]             state;
    logic [SelW-1:0]        ptr;
    logic                   owner_held;
    logic                   tmo_hit;
    logic                   rearb;
    logic [NumRequests-1:0] arb_req;
    logic                   win_found;
    logic [SelW-1:0]        win_idx;
    logic [SelW-1:0]        scan;
    logic [SelW:0]          sum;
    logic [NumRequests-1:0] win_oh;

    assign owner_held = (state == StBusy) && |(request & grant);
    assign rearb      = !owner_held || tmo_hit;
    // On a timeout the owner is masked so a waiting requester must win.
    assign arb_req    = tmo_hit ? (request & ~grant) : request;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        sum       = '0;
        for (int i = 0; i < NumRequests; i++) begin
            if (Mode == 1) begin
                scan = SelW'(i);
            end else begin
                sum = {1'b0, ptr} + (SelW+1)'(i);
                if (sum >= NumReqW) begin
                    sum = sum - NumReqW;
                end
                scan = sum[SelW-1:0];
            end
            if (!win_found && arb_req[scan]) begin
                win_found = 1'b1;
                win_idx   = scan;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            grant       <= '0;
            grant_valid <= 1'b0;
            select      <= '0;
            ptr         <= '0;
        end else if (rearb) begin
            if (win_found) begin
                state       <= StBusy;
                grant       <= win_oh;
                grant_valid <= 1'b1;
                select      <= win_idx;
                ptr         <= (win_idx == LastIdx) ? '0 : win_idx + SelW'(1);
            end else begin
                state       <= StIdle;
                grant       <= '0;
                grant_valid <= 1'b0;
                select      <= '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int              CntW   = $clog2(MaxHold) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MaxHold - 1);

    logic [CntW-1:0] hold_cnt;
    logic            preempt_q;

    assign tmo_hit = owner_held && (hold_cnt == CntMax) && |(request & ~grant);
    assign preempt = preempt_q;

    // Saturates at MaxHold-1 so a lone owner keeps the resource but is preempted the moment anyone else asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            preempt_q <= 1'b0;
        end else if (rearb) begin
            hold_cnt  <= '0;
            preempt_q <= tmo_hit;
        end else begin
            preempt_q <= 1'b0;
            if (hold_cnt != CntMax) begin
                hold_cnt <= hold_cnt + CntW'(1);
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a Mode 0 and a Mode 1 instance share one request stream and are compared every cycle against a behavioural model.
module tb_rr_arbiter;

    localparam int N       = 4;
    localparam int MaxHold = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] request;
    logic [N-1:0] grant0, grant1;
    logic         gv0, gv1;
    logic [1:0]   sel0, sel1;
    logic         pre0, pre1;

    always #5 clk = ~clk;

    rr_arbiter #(.NumRequests(N), .Mode(0), .MaxHold(MaxHold)) u_rr (
        .clk(clk), .rst_n(rst_n), .request(request),
        .grant(grant0), .grant_valid(gv0), .select(sel0), .preempt(pre0)
    );

    rr_arbiter #(.NumRequests(N), .Mode(1), .MaxHold(MaxHold)) u_fp (
        .clk(clk), .rst_n(rst_n), .request(request),
        .grant(grant1), .grant_valid(gv1), .select(sel1), .preempt(pre1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model, index 0 = round-robin instance, 1 = fixed-priority instance.
    int m_owner [2];
    int m_ptr   [2];
    int m_hold  [2];
    bit m_pre   [2];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_ptr[m]   = 0;
            m_hold[m]  = 0;
            m_pre[m]   = 1'b0;
        end
    endfunction

    function automatic void model_step(input int m, input logic [N-1:0] req);
        logic [N-1:0] cand;
        bit held, others, tmo;
        int w, idx;
        held   = 1'b0;
        others = 1'b0;
        if (m_owner[m] >= 0) begin
            held = req[m_owner[m]];
            for (int k = 0; k < N; k++)
                if (k != m_owner[m] && req[k]) others = 1'b1;
        end
        tmo      = TimeoutEn && held && (m_hold[m] == MaxHold - 1) && others;
        m_pre[m] = 1'b0;
        if (held && !tmo) begin
            if (m_hold[m] < MaxHold - 1) m_hold[m]++;
        end else begin
            cand = req;
            if (tmo) cand[m_owner[m]] = 1'b0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m == 1) ? k : (m_ptr[m] + k) % N;
                if (w < 0 && cand[idx]) w = idx;
            end
            if (w >= 0) begin
                m_owner[m] = w;
                m_ptr[m]   = (w + 1) % N;
                m_hold[m]  = 0;
                m_pre[m]   = tmo;
            end else begin
                m_owner[m] = -1;
            end
        end
    endfunction

    function automatic logic [31:0] exp_grant(input int m);
        return (m_owner[m] < 0) ? 32'd0 : (32'd1 << m_owner[m]);
    endfunction

    task automatic check_outputs();
        check("rr_grant",   32'(grant0), exp_grant(0));
        check("rr_valid",   32'(gv0),    32'(m_owner[0] >= 0));
        check("rr_select",  32'(sel0),   (m_owner[0] < 0) ? 32'd0 : 32'(m_owner[0]));
        check("rr_preempt", 32'(pre0),   32'(m_pre[0]));
        check("fp_grant",   32'(grant1), exp_grant(1));
        check("fp_valid",   32'(gv1),    32'(m_owner[1] >= 0));
        check("fp_select",  32'(sel1),   (m_owner[1] < 0) ? 32'd0 : 32'(m_owner[1]));
        check("fp_preempt", 32'(pre1),   32'(m_pre[1]));
    endtask

    // Called at a falling edge: apply request, let one rising edge pass, check at the next falling edge.
    task automatic drive(input logic [N-1:0] r);
        request = r;
        model_step(0, r);
        model_step(1, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'({grant0, grant1}), 32'd0);
        check({tag, "_valid"}, 32'({gv0, gv1}),       32'd0);
        check({tag, "_select"}, 32'({sel0, sel1}),    32'd0);
        check({tag, "_preempt"}, 32'({pre0, pre1}),   32'd0);
    endtask

    task automatic random_run(input int cycles);
        logic [N-1:0] r;
        logic [31:0]  flip;
        r = request;
        for (int c = 0; c < cycles; c++) begin
            flip = $urandom & $urandom;
            r    = r ^ flip[N-1:0];
            if ($urandom_range(0, 31) == 0) r = '0;
            drive(r);
        end
    endtask

    logic [N-1:0] fair_seq [5];

    initial begin
        fair_seq[0] = 4'b0001;
        fair_seq[1] = 4'b0010;
        fair_seq[2] = 4'b0100;
        fair_seq[3] = 4'b1000;
        fair_seq[4] = 4'b0001;

        rst_n   = 1'b0;
        request = '0;
        model_reset();
        @(negedge clk);
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        random_run(200);

        // Asynchronous reset in the middle of traffic
        request = 4'b1111;
        rst_n   = 1'b0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1111);
        check("post_rst_rr", 32'(grant0), 32'b0001);
        check("post_rst_fp", 32'(grant1), 32'b0001);

        // Round-robin fairness: each owner holds two cycles then drops for one
        for (int k = 0; k < 4; k++) begin
            drive(4'b1111);
            drive(4'b1111 & ~fair_seq[k]);
            check("fair_seq", 32'(grant0), 32'(fair_seq[k+1]));
            check("fair_no_bubble", 32'(gv0), 32'd1);
        end

        // Fixed priority: index 1 beats index 3 on re-arbitration
        drive(4'b0000);
        drive(4'b1011);
        check("fp_first", 32'(grant1), 32'b0001);
        drive(4'b1010);
        check("fp_rearb", 32'(grant1), 32'b0010);
        drive(4'b1010);
        check("fp_hold", 32'(grant1), 32'b0010);

        // Single request, then owner 2 holds while other bits toggle
        drive(4'b0000);
        drive(4'b0100);
        check("single_grant", 32'(grant0), 32'b0100);
        check("single_select", 32'(sel0), 32'd2);
        for (int k = 0; k < 10; k++) begin
            drive((k % 2 == 1) ? 4'b1101 : 4'b0100);
`ifndef ARB_TIMEOUT_EN
            check("hold_owner", 32'(grant0), 32'b0100);
`endif
        end
`ifndef ARB_TIMEOUT_EN
        drive(4'b1011);
        check("hold_ptr_rr", 32'(grant0), 32'b1000);
        check("hold_ptr_fp", 32'(grant1), 32'b0001);
`endif
        drive(4'b0000);
        check("release_idle", 32'(gv0), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // Owner 0 monopolises; requester 1 arrives at cycle 2 and is served after 8 grant cycles
        drive(4'b0001);
        drive(4'b0001);
        for (int k = 0; k < 6; k++) begin
            drive(4'b0011);
            check("tmo_wait", 32'({grant0, pre0}), 32'({4'b0001, 1'b0}));
        end
        drive(4'b0011);
        check("tmo_preempt_rr", 32'({grant0, pre0}), 32'({4'b0010, 1'b1}));
        check("tmo_preempt_fp", 32'({grant1, pre1}), 32'({4'b0010, 1'b1}));
        drive(4'b0011);
        check("tmo_pulse_end", 32'(pre0), 32'd0);
        drive(4'b0000);
        for (int k = 0; k < 21; k++) begin
            drive(4'b0001);
            check("tmo_alone", 32'({grant0, pre0}), 32'({4'b0001, 1'b0}));
        end
`endif

        random_run(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
